// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: per-stage enables and flushes,
// a memory-wait/halt state machine, and cycle/stall/redirect performance counters.
module pipeline_hazard_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             dmemren_mem,
   input  logic             dmemwen_mem,
   input  logic             memren_ex,
   input  logic [4:0]       regwrite_ex,
   input  logic [4:0]       rs_id,
   input  logic [4:0]       rt_id,
   input  logic             uses_rt_id,
   input  logic             jump_id,
   input  logic             branch_taken_mem,
   input  logic             halt_wb,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             idex_en,
   output logic             exmem_en,
   output logic             memwb_en,
   output logic             flush_ifid,
   output logic             flush_idex,
   output logic             flush_exmem,
   output logic             halted,
   output logic [CNT_W-1:0] cyc_count,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   typedef enum logic [1:0] {RUN, MEM_WAIT, HALTED} state_t;

   state_t           r_state;
   logic             r_halted;
   logic [CNT_W-1:0] r_cyc_count;
   logic [CNT_W-1:0] r_stall_count;
   logic [CNT_W-1:0] r_flush_count;

   logic w_memop;
   logic w_hold;
   logic w_adv;
   logic w_lu;
   logic w_redirect;

   assign w_memop = dmemren_mem | dmemwen_mem;
   assign w_hold  = halt_wb | (r_state == HALTED);
   assign w_adv   = ihit & ~w_memop & ~w_hold;
   assign w_lu    = memren_ex & (regwrite_ex != 5'd0) &
                    ((regwrite_ex == rs_id) | (uses_rt_id & (regwrite_ex == rt_id)));
   // A load-use bubble outranks the jump; the jump re-presents after the bubble.
   assign w_redirect = w_adv & (branch_taken_mem | (jump_id & ~w_lu));

   assign memwb_en = ~w_hold & (dhit | w_adv);

   // Flushes stay low whenever the pipe is not advancing: a flush beats the
   // register enable and would wipe out held state.
   always_comb begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      flush_ifid  = 1'b0;
      flush_idex  = 1'b0;
      flush_exmem = 1'b0;
      if (w_adv) begin
         pc_en    = 1'b1;
         ifid_en  = 1'b1;
         idex_en  = 1'b1;
         exmem_en = 1'b1;
         if (branch_taken_mem) begin
            flush_ifid  = 1'b1;
            flush_idex  = 1'b1;
            flush_exmem = 1'b1;
         end else if (w_lu) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            flush_idex = 1'b1;
         end else if (jump_id) begin
            flush_ifid = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state  <= RUN;
         r_halted <= 1'b0;
      end else if (halt_wb || r_state == HALTED) begin
         r_state  <= HALTED;
         r_halted <= 1'b1;
      end else begin
         r_halted <= 1'b0;
         case (r_state)
            RUN:      if (w_memop && !dhit) r_state <= MEM_WAIT;
            MEM_WAIT: if (dhit) r_state <= RUN;
            default:  r_state <= RUN;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_cyc_count   <= '0;
         r_stall_count <= '0;
         r_flush_count <= '0;
      end else if (r_state != HALTED) begin
         r_cyc_count <= r_cyc_count + 1'b1;
         if (!pc_en)     r_stall_count <= r_stall_count + 1'b1;
         if (w_redirect) r_flush_count <= r_flush_count + 1'b1;
      end
   end

   assign halted      = r_halted;
   assign cyc_count   = r_cyc_count;
   assign stall_count = r_stall_count;
   assign flush_count = r_flush_count;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: inputs driven on the falling edge,
// combinational outputs checked 1ns later, counters checked one cycle on.
module tb_pipeline_hazard_ctrl;

   localparam int CNT_W = 32;

   logic             CLK = 1'b0;
   logic             nRST;
   logic             ihit, dhit, dmemren_mem, dmemwen_mem, memren_ex;
   logic [4:0]       regwrite_ex, rs_id, rt_id;
   logic             uses_rt_id, jump_id, branch_taken_mem, halt_wb;
   logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
   logic             flush_ifid, flush_idex, flush_exmem, halted;
   logic [CNT_W-1:0] cyc_count, stall_count, flush_count;

   int n_cmp = 0;
   int n_err = 0;

   pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
      .dmemren_mem(dmemren_mem), .dmemwen_mem(dmemwen_mem),
      .memren_ex(memren_ex), .regwrite_ex(regwrite_ex),
      .rs_id(rs_id), .rt_id(rt_id), .uses_rt_id(uses_rt_id),
      .jump_id(jump_id), .branch_taken_mem(branch_taken_mem), .halt_wb(halt_wb),
      .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
      .exmem_en(exmem_en), .memwb_en(memwb_en),
      .flush_ifid(flush_ifid), .flush_idex(flush_idex), .flush_exmem(flush_exmem),
      .halted(halted), .cyc_count(cyc_count), .stall_count(stall_count),
      .flush_count(flush_count)
   );

   always #5 CLK = ~CLK;

   // enables packed as {pc,ifid,idex,exmem,memwb}; flushes as {ifid,idex,exmem}
   logic [4:0] en;
   logic [2:0] fl;
   assign en = {pc_en, ifid_en, idex_en, exmem_en, memwb_en};
   assign fl = {flush_ifid, flush_idex, flush_exmem};

   task automatic idle_inputs();
      ihit = 0; dhit = 0; dmemren_mem = 0; dmemwen_mem = 0; memren_ex = 0;
      regwrite_ex = 0; rs_id = 0; rt_id = 0; uses_rt_id = 0;
      jump_id = 0; branch_taken_mem = 0; halt_wb = 0;
   endtask

   // Leaves the bench on a falling edge with nRST released and counters at zero.
   task automatic apply_reset();
      idle_inputs();
      nRST = 0;
      @(negedge CLK);
      @(negedge CLK);
      nRST = 1;
   endtask

   task automatic test_reset();
      apply_reset();
      #1;
      n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted got %b want 0", halted); end
      n_cmp++; if ({cyc_count, stall_count, flush_count} !== '0) begin n_err++;
         $display("FAIL reset_counters got %0d/%0d/%0d want 0/0/0", cyc_count, stall_count, flush_count); end
      n_cmp++; if (en !== 5'b00000 || fl !== 3'b000) begin n_err++;
         $display("FAIL reset_idle_outputs got en=%b fl=%b want en=00000 fl=000", en, fl); end
   endtask

   task automatic test_steady();
      apply_reset();
      ihit = 1;
      #1;
      n_cmp++; if (en !== 5'b11111 || fl !== 3'b000) begin n_err++;
         $display("FAIL steady_outputs got en=%b fl=%b want en=11111 fl=000", en, fl); end
      repeat (10) @(negedge CLK);
      n_cmp++; if (cyc_count !== 32'd10 || stall_count !== 32'd0) begin n_err++;
         $display("FAIL steady_counts got cyc=%0d stall=%0d want cyc=10 stall=0", cyc_count, stall_count); end
   endtask

   task automatic test_load_use();
      apply_reset();
      ihit = 1; memren_ex = 1; regwrite_ex = 5; rs_id = 5;
      #1;
      n_cmp++; if (en !== 5'b00111 || fl !== 3'b010) begin n_err++;
         $display("FAIL lu_rs_outputs got en=%b fl=%b want en=00111 fl=010", en, fl); end
      @(negedge CLK);
      regwrite_ex = 6;
      #1;
      n_cmp++; if (en !== 5'b11111 || fl !== 3'b000) begin n_err++;
         $display("FAIL lu_after_outputs got en=%b fl=%b want en=11111 fl=000", en, fl); end
      n_cmp++; if (stall_count !== 32'd1 || cyc_count !== 32'd1 || flush_count !== 32'd0) begin n_err++;
         $display("FAIL lu_counts got cyc=%0d stall=%0d flush=%0d want 1/1/0", cyc_count, stall_count, flush_count); end
      // rt match only counts when the instruction reads rt
      rs_id = 1; rt_id = 6; uses_rt_id = 1;
      #1;
      n_cmp++; if (en !== 5'b00111 || fl !== 3'b010) begin n_err++;
         $display("FAIL lu_rt_outputs got en=%b fl=%b want en=00111 fl=010", en, fl); end
      uses_rt_id = 0;
      #1;
      n_cmp++; if (en !== 5'b11111 || fl !== 3'b000) begin n_err++;
         $display("FAIL lu_rt_unused got en=%b fl=%b want en=11111 fl=000", en, fl); end
      regwrite_ex = 0; rs_id = 0; rt_id = 0; uses_rt_id = 1;
      #1;
      n_cmp++; if (en !== 5'b11111 || fl !== 3'b000) begin n_err++;
         $display("FAIL lu_r0_no_stall got en=%b fl=%b want en=11111 fl=000", en, fl); end
   endtask

   task automatic test_mem_wait();
      apply_reset();
      ihit = 1; dmemren_mem = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_cmp++; if (en !== 5'b00000 || fl !== 3'b000) begin n_err++;
            $display("FAIL memwait_cycle%0d got en=%b fl=%b want en=00000 fl=000", i, en, fl); end
         @(negedge CLK);
      end
      dhit = 1;
      #1;
      n_cmp++; if (en !== 5'b00001 || fl !== 3'b000) begin n_err++;
         $display("FAIL memwait_dhit got en=%b fl=%b want en=00001 fl=000", en, fl); end
      @(negedge CLK);
      dhit = 0; dmemren_mem = 0;
      #1;
      n_cmp++; if (en !== 5'b11111) begin n_err++;
         $display("FAIL memwait_resume got en=%b want 11111", en); end
      n_cmp++; if (cyc_count !== 32'd4 || stall_count !== 32'd4) begin n_err++;
         $display("FAIL memwait_counts got cyc=%0d stall=%0d want 4/4", cyc_count, stall_count); end
      ihit = 0; dhit = 1;
      #1;
      n_cmp++; if (en !== 5'b00001 || fl !== 3'b000) begin n_err++;
         $display("FAIL dhit_no_ihit got en=%b fl=%b want en=00001 fl=000", en, fl); end
      // a store stalls the same way
      ihit = 1; dhit = 0; dmemwen_mem = 1;
      #1;
      n_cmp++; if (en !== 5'b00000) begin n_err++;
         $display("FAIL store_wait got en=%b want 00000", en); end
   endtask

   task automatic test_branch();
      apply_reset();
      ihit = 1; branch_taken_mem = 1; jump_id = 1;
      memren_ex = 1; regwrite_ex = 5; rs_id = 5;
      #1;
      n_cmp++; if (en !== 5'b11111 || fl !== 3'b111) begin n_err++;
         $display("FAIL branch_outputs got en=%b fl=%b want en=11111 fl=111", en, fl); end
      @(negedge CLK);
      n_cmp++; if (flush_count !== 32'd1 || stall_count !== 32'd0) begin n_err++;
         $display("FAIL branch_counts got flush=%0d stall=%0d want 1/0", flush_count, stall_count); end
      ihit = 0;
      #1;
      n_cmp++; if (en !== 5'b00000 || fl !== 3'b000) begin n_err++;
         $display("FAIL branch_no_ihit got en=%b fl=%b want en=00000 fl=000", en, fl); end
      @(negedge CLK);
      ihit = 1; branch_taken_mem = 0;
      #1;
      n_cmp++; if (en !== 5'b00111 || fl !== 3'b010) begin n_err++;
         $display("FAIL jump_lu_outputs got en=%b fl=%b want en=00111 fl=010", en, fl); end
      @(negedge CLK);
      memren_ex = 0;
      #1;
      n_cmp++; if (en !== 5'b11111 || fl !== 3'b100) begin n_err++;
         $display("FAIL jump_outputs got en=%b fl=%b want en=11111 fl=100", en, fl); end
      @(negedge CLK);
      n_cmp++; if (flush_count !== 32'd2) begin n_err++;
         $display("FAIL jump_flush_count got %0d want 2", flush_count); end
   endtask

   task automatic test_halt();
      apply_reset();
      ihit = 1;
      @(negedge CLK);
      halt_wb = 1; dhit = 1;
      #1;
      n_cmp++; if (en !== 5'b00000 || fl !== 3'b000 || halted !== 1'b0) begin n_err++;
         $display("FAIL halt_same_cycle got en=%b fl=%b halted=%b want 00000/000/0", en, fl, halted); end
      @(negedge CLK);
      halt_wb = 0;
      #1;
      n_cmp++; if (halted !== 1'b1 || en !== 5'b00000) begin n_err++;
         $display("FAIL halt_next got halted=%b en=%b want 1/00000", halted, en); end
      n_cmp++; if (cyc_count !== 32'd2 || stall_count !== 32'd1) begin n_err++;
         $display("FAIL halt_counts got cyc=%0d stall=%0d want 2/1", cyc_count, stall_count); end
      for (int i = 0; i < 5; i++) begin
         ihit = i[0]; jump_id = i[1];
         @(negedge CLK);
      end
      #1;
      n_cmp++; if (halted !== 1'b1 || en !== 5'b00000 || cyc_count !== 32'd2 ||
                   stall_count !== 32'd1 || flush_count !== 32'd0) begin n_err++;
         $display("FAIL halt_frozen got halted=%b en=%b cyc=%0d stall=%0d flush=%0d want 1/00000/2/1/0",
                  halted, en, cyc_count, stall_count, flush_count); end
      nRST = 0;
      #1;
      n_cmp++; if (halted !== 1'b0 || cyc_count !== 32'd0 || stall_count !== 32'd0) begin n_err++;
         $display("FAIL halt_async_reset got halted=%b cyc=%0d stall=%0d want 0/0/0", halted, cyc_count, stall_count); end
      @(negedge CLK);
      nRST = 1; ihit = 1; jump_id = 0; dhit = 0;
      #1;
      n_cmp++; if (en !== 5'b11111) begin n_err++;
         $display("FAIL halt_rerun got en=%b want 11111", en); end
   endtask

   initial begin
      test_reset();
      test_steady();
      test_load_use();
      test_mem_wait();
      test_branch();
      test_halt();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage MIPS pipeline. It takes cache hit signals, hazard-relevant fields from the ID, EX and MEM stages, and the WB halt. From these it generates the per-stage enables and flushes for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus the PC enable. It holds a small state machine for memory wait and halt, and keeps performance counters.

## Interface
- CNT_W, 32, width of performance counters
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- ihit  in  1  instruction fetch completed this cycle
- dhit  in  1  data access completed this cycle
- dmemren_mem, dmemwen_mem  in  1 each  load/store occupying MEM stage
- memren_ex  in  1  EX-stage instruction is a load
- regwrite_ex  in  5  EX-stage destination register
- rs_id, rt_id  in  5 each  ID-stage source registers
- uses_rt_id  in  1  ID-stage instruction reads rt
- jump_id  in  1  ID-stage j/jal/jr redirecting PC
- branch_taken_mem  in  1  taken branch resolved in MEM
- halt_wb  in  1  halt instruction in WB
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  stage advance enables
- flush_ifid, flush_idex, flush_exmem  out  1 each  synchronous stage clears
- halted  out  1  registered, processor halted
- cyc_count, stall_count  out  CNT_W each  cycle and stall counters
- flush_count  out  CNT_W  taken-redirect event counter

## Operation
- Derived signals:
  - memop = dmemren_mem | dmemwen_mem.
  - adv = ihit & !memop & !hold, where hold = halt_wb | (state==HALTED).
  - lu = memren_ex & (regwrite_ex!=0) & ((regwrite_ex==rs_id) | (uses_rt_id & regwrite_ex==rt_id)).
- States:
  - RUN (reset).
  - MEM_WAIT: memop & !dhit; returns to RUN on dhit.
  - HALTED: entered from any state when halt_wb=1; exits only on nRST.
- memwb_en = !hold & (dhit | adv).
- When adv=0: pc_en = ifid_en = idex_en = exmem_en = 0, and all flushes = 0.
  - Flushes are never asserted in a non-advancing cycle. The registers give flush priority over enable, so a flush in such a cycle would destroy held state.
- When adv=1, priority from highest to lowest:
  1. branch_taken_mem: flush_ifid = flush_idex = flush_exmem = 1; all enables 1 (PC loads target).
  2. lu: pc_en = ifid_en = 0; idex_en = exmem_en = 1; flush_idex = 1 (one bubble).
  3. jump_id: flush_ifid = 1; all enables 1.
  4. Otherwise: all enables 1, no flushes.
- lu and jump_id together: lu wins. The jump re-presents next cycle after the bubble.
- Counters wrap modulo 2^CNT_W:
  - cyc_count +1 every cycle state!=HALTED.
  - stall_count +1 every cycle state!=HALTED and pc_en=0.
  - flush_count +1 on each adv cycle with branch_taken_mem or jump_id active (lu cycles excluded).
- All counters freeze in HALTED.

## Timing
- Reset: state=RUN, halted=0, all counters 0. All enable/flush outputs are combinational and depend only on current inputs/state.
- Enables and flushes are combinational from inputs; the registers act on the next CLK edge. No added latency.
- Load-use costs exactly 1 stall cycle: next cycle the load is in MEM and lu is false.
- Taken branch costs 3 squashed instructions; jump costs 1.
- halt_wb=1: enables zero in the same cycle; halted=1 from the next edge on.
- nRST mid-MEM_WAIT or mid-HALTED: immediate return to RUN, counters cleared.
- dhit with ihit=0: only memwb_en asserts. Upstream stages hold until the next ihit.

## Test plan
- Reset, ihit=1 steady, no hazards:
  - All enables 1, flushes 0.
  - After 10 cycles: cyc_count=10, stall_count=0.
- Load-use: memren_ex=1, regwrite_ex=5, rs_id=5, ihit=1.
  - Same cycle: pc_en=0, ifid_en=0, flush_idex=1, exmem_en=1.
  - Next cycle with regwrite_ex changed: normal advance; stall_count=1.
- Memory wait: dmemren_mem=1, dhit=0 for 3 cycles, then dhit=1.
  - 3 cycles of all enables 0 in MEM_WAIT.
  - dhit cycle: memwb_en=1, pc_en=0; state returns to RUN.
- Taken branch with ihit=1: branch_taken_mem=1, plus lu and jump_id both 1.
  - Three flushes asserted, all enables 1, flush_count +1.
  - Same branch with ihit=0: all enables and flushes 0.
- Halt: halt_wb=1.
  - Enables 0 immediately; halted=1 next cycle; counters frozen.
  - Further ihit pulses are ignored until nRST.
- regwrite_ex=0 with memren_ex=1 and rs_id=0: no stall asserted.
